// File: rtl/trap_controller.sv
// trap_controller: commits the oldest pending exception, redirects fetch to
// the trap vector and holds fetch stalled while the pipeline drains.
// Optional feature macro TRAP_MRET_EN: when defined, MRET in IDLE redirects
// fetch to MEPC through the same REDIRECT/DRAIN sequence (no commit pulse).
module trap_controller #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        loadMisaligned,
  input  logic        storeMisaligned,
  input  logic        fetchMisaligned,
  input  logic        illegalInstruction,
  input  logic        ebreak,
  input  logic        ecall,
  input  logic        mretValid,
  input  logic [31:0] trapVector,
  input  logic [31:0] mepc,
  output logic        controlReset,
  output logic [3:0]  mcause,
  output logic        redirectValid,
  output logic [31:0] redirectPC,
  output logic        fetchStall
);

  typedef enum logic [1:0] {IDLE = 2'd0, REDIRECT = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state, next_state;
  logic [3:0]  counter;
  logic [31:0] target, target_d;
  logic        load_target;
  logic        trap_req;
  logic [3:0]  cause_code;

  assign trap_req = storeMisaligned | loadMisaligned | fetchMisaligned |
                    illegalInstruction | ebreak | ecall;

`ifndef TRAP_MRET_EN
  // MRET is not supported in this build; the ports are kept but consumed here.
  logic unused_mret;
  assign unused_mret = ^{mretValid, mepc};
`endif

  // Oldest pipeline stage wins: MEM/WB faults, then EX/MEM, then ID/EX.
  always_comb begin
    cause_code = 4'd0;
    if (storeMisaligned)         cause_code = 4'd6;
    else if (loadMisaligned)     cause_code = 4'd4;
    else if (fetchMisaligned)    cause_code = 4'd0;
    else if (illegalInstruction) cause_code = 4'd2;
    else if (ebreak)             cause_code = 4'd3;
    else if (ecall)              cause_code = 4'hB;
  end

  // Next-state and output decode; exception inputs only matter in IDLE and
  // everything is forced quiet while reset is held.
  always_comb begin
    next_state    = state;
    controlReset  = 1'b0;
    mcause        = 4'd0;
    redirectValid = 1'b0;
    redirectPC    = 32'd0;
    fetchStall    = 1'b0;
    load_target   = 1'b0;
    target_d      = target;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (trap_req) begin
            controlReset = 1'b1;
            mcause       = cause_code;
            load_target  = 1'b1;
            target_d     = trapVector;
            next_state   = REDIRECT;
          end
`ifdef TRAP_MRET_EN
          else if (mretValid) begin
            load_target = 1'b1;
            target_d    = mepc;
            next_state  = REDIRECT;
          end
`endif
        end
        REDIRECT: begin
          redirectValid = 1'b1;
          redirectPC    = target;
          fetchStall    = 1'b1;
          next_state    = DRAIN;
        end
        DRAIN: begin
          fetchStall = 1'b1;
          if (counter == 4'd0) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State, drain counter and redirect target; reset aborts any sequence.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= 4'd0;
      target  <= 32'd0;
    end else begin
      state <= next_state;
      if (load_target) target <= target_d;
      case (state)
        REDIRECT: counter <= DRAIN_LOAD;
        DRAIN:    if (counter != 4'd0) counter <= counter - 4'd1;
        default:  counter <= counter;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller (DRAIN_CYCLES = 2): a vector table of
// single traps plus hand sequences for back-to-back and mid-drain reset.
module tb_trap_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  exc;   // {store, load, fetch, illegal, ebreak, ecall}
  logic        mret;
  logic [31:0] tvec;
  logic [31:0] mepc_v;
  logic        controlReset;
  logic [3:0]  mcause;
  logic        redirectValid;
  logic [31:0] redirectPC;
  logic        fetchStall;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] E_ST = 6'b100000, E_LD = 6'b010000, E_FE = 6'b001000,
                         E_IL = 6'b000100, E_EB = 6'b000010, E_EC = 6'b000001;

  trap_controller #(.DRAIN_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .loadMisaligned(exc[4]), .storeMisaligned(exc[5]), .fetchMisaligned(exc[3]),
    .illegalInstruction(exc[2]), .ebreak(exc[1]), .ecall(exc[0]),
    .mretValid(mret), .trapVector(tvec), .mepc(mepc_v),
    .controlReset(controlReset), .mcause(mcause),
    .redirectValid(redirectValid), .redirectPC(redirectPC), .fetchStall(fetchStall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  exc;
    logic        mret;
    logic [31:0] tvec;
    logic        cr;
    logic [3:0]  cause;
    logic        redir;
    logic [31:0] pc;
  } vec_t;

  vec_t vt[11];

  initial begin
    vt[0]  = '{E_EC,               1'b0, 32'h0000_0100, 1'b1, 4'hB, 1'b1, 32'h0000_0100};
    vt[1]  = '{E_ST | E_LD | E_IL, 1'b0, 32'h0000_0104, 1'b1, 4'h6, 1'b1, 32'h0000_0104};
    vt[2]  = '{E_LD,               1'b0, 32'h0000_0108, 1'b1, 4'h4, 1'b1, 32'h0000_0108};
    vt[3]  = '{E_FE,               1'b0, 32'h0000_010C, 1'b1, 4'h0, 1'b1, 32'h0000_010C};
    vt[4]  = '{E_IL,               1'b0, 32'h0000_0110, 1'b1, 4'h2, 1'b1, 32'h0000_0110};
    vt[5]  = '{E_EB,               1'b0, 32'h0000_0114, 1'b1, 4'h3, 1'b1, 32'h0000_0114};
    vt[6]  = '{E_LD | E_FE,        1'b0, 32'h8000_0000, 1'b1, 4'h4, 1'b1, 32'h8000_0000};
    vt[7]  = '{E_EB | E_EC,        1'b0, 32'hFFFF_FFFC, 1'b1, 4'h3, 1'b1, 32'hFFFF_FFFC};
    vt[8]  = '{6'b0,               1'b0, 32'h0000_0120, 1'b0, 4'h0, 1'b0, 32'h0};
`ifdef TRAP_MRET_EN
    vt[9]  = '{6'b0,               1'b1, 32'h0000_0124, 1'b0, 4'h0, 1'b1, 32'h0000_0480};
`else
    vt[9]  = '{6'b0,               1'b1, 32'h0000_0124, 1'b0, 4'h0, 1'b0, 32'h0};
`endif
    vt[10] = '{E_FE,               1'b1, 32'h0000_0128, 1'b1, 4'h0, 1'b1, 32'h0000_0128};

    // Reset state: outputs quiet even with an exception presented.
    reset = 1'b1; exc = E_EC; mret = 1'b0; tvec = 32'h100; mepc_v = 32'h480;
    #3;
    chk("rst_controlReset", {31'b0, controlReset}, 32'd0);
    chk("rst_mcause", {28'b0, mcause}, 32'd0);
    chk("rst_fetchStall", {31'b0, fetchStall}, 32'd0);
    chk("rst_redirectValid", {31'b0, redirectValid}, 32'd0);
    @(negedge clock); reset = 1'b0; exc = 6'b0;

    // Table of single-trap vectors, each followed by its full stall sequence.
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      exc = vt[i].exc; mret = vt[i].mret; tvec = vt[i].tvec;
      #1;
      chk($sformatf("v%0d_controlReset", i), {31'b0, controlReset}, {31'b0, vt[i].cr});
      chk($sformatf("v%0d_mcause", i), {28'b0, mcause}, {28'b0, vt[i].cause});
      chk($sformatf("v%0d_idle_stall", i), {31'b0, fetchStall}, 32'd0);
      @(negedge clock);
      exc = 6'b0; mret = 1'b0; tvec = 32'hDEAD_0000;
      #1;
      chk($sformatf("v%0d_redirectValid", i), {31'b0, redirectValid}, {31'b0, vt[i].redir});
      chk($sformatf("v%0d_redirectPC", i), redirectPC, vt[i].pc);
      chk($sformatf("v%0d_redir_stall", i), {31'b0, fetchStall}, {31'b0, vt[i].redir});
      chk($sformatf("v%0d_redir_cr", i), {31'b0, controlReset}, 32'd0);
      for (int k = 0; k < 2; k++) begin
        @(negedge clock); #1;
        chk($sformatf("v%0d_drain%0d_stall", i, k), {31'b0, fetchStall}, {31'b0, vt[i].redir});
        chk($sformatf("v%0d_drain%0d_rv", i, k), {31'b0, redirectValid}, 32'd0);
        chk($sformatf("v%0d_drain%0d_pc", i, k), redirectPC, 32'd0);
      end
      @(negedge clock); #1;
      chk($sformatf("v%0d_done_stall", i), {31'b0, fetchStall}, 32'd0);
    end

    // Exceptions arriving during REDIRECT/DRAIN are ignored; next trap at +4.
    @(negedge clock); tvec = 32'h200; exc = E_EC; #1;
    chk("b2b_first_cr", {31'b0, controlReset}, 32'd1);
    @(negedge clock); exc = E_EC; #1;
    chk("b2b_t1_cr", {31'b0, controlReset}, 32'd0);
    chk("b2b_t1_pc", redirectPC, 32'h200);
    @(negedge clock); exc = E_IL; #1;
    chk("b2b_t2_cr", {31'b0, controlReset}, 32'd0);
    @(negedge clock); exc = E_EB; #1;
    chk("b2b_t3_cr", {31'b0, controlReset}, 32'd0);
    chk("b2b_t3_stall", {31'b0, fetchStall}, 32'd1);
    @(negedge clock); exc = E_EB; #1;
    chk("b2b_t4_cr", {31'b0, controlReset}, 32'd1);
    chk("b2b_t4_mcause", {28'b0, mcause}, 32'd3);
    @(negedge clock); exc = 6'b0;
    repeat (3) @(negedge clock);

    // Reset between edges during DRAIN aborts immediately.
    tvec = 32'h300; exc = E_LD; #1;
    chk("rstd_cr", {31'b0, controlReset}, 32'd1);
    chk("rstd_mcause", {28'b0, mcause}, 32'd4);
    @(negedge clock); exc = 6'b0;
    @(negedge clock); #1;
    chk("rstd_drain_stall", {31'b0, fetchStall}, 32'd1);
    #2; reset = 1'b1; exc = E_EB; #1;
    chk("rstd_async_stall", {31'b0, fetchStall}, 32'd0);
    chk("rstd_async_cr", {31'b0, controlReset}, 32'd0);
    chk("rstd_async_rv", {31'b0, redirectValid}, 32'd0);
    @(negedge clock); reset = 1'b0; tvec = 32'h340; exc = E_EB; #1;
    chk("rstd_after_cr", {31'b0, controlReset}, 32'd1);
    chk("rstd_after_mcause", {28'b0, mcause}, 32'd3);
    @(negedge clock); exc = 6'b0; #1;
    chk("rstd_after_pc", redirectPC, 32'h340);
    repeat (3) @(negedge clock);
    #1;
    chk("rstd_final_stall", {31'b0, fetchStall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
